// File: rtl/imem_fetch_if.sv
// Fetch/load port bundle between the IF stage (master) and imem_fetch_unit (slave).
interface imem_fetch_if #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32
);
  logic                  fetch_req_valid;
  logic                  fetch_req_ready;
  logic [ADDR_WIDTH+1:0] fetch_addr;
  logic                  fetch_flush;
  logic                  fetch_rsp_valid;
  logic                  fetch_rsp_ready;
  logic [DATA_WIDTH-1:0] fetch_rsp_data;
  logic [ADDR_WIDTH+1:0] fetch_rsp_addr;
  logic                  fetch_rsp_err;
  logic                  load_mode;
  logic                  load_we;
  logic [ADDR_WIDTH-1:0] load_addr;
  logic [DATA_WIDTH-1:0] load_data;

  modport master (
    output fetch_req_valid, fetch_addr, fetch_flush, fetch_rsp_ready,
           load_mode, load_we, load_addr, load_data,
    input  fetch_req_ready, fetch_rsp_valid, fetch_rsp_data, fetch_rsp_addr, fetch_rsp_err
  );

  modport slave (
    input  fetch_req_valid, fetch_addr, fetch_flush, fetch_rsp_ready,
           load_mode, load_we, load_addr, load_data,
    output fetch_req_ready, fetch_rsp_valid, fetch_rsp_data, fetch_rsp_addr, fetch_rsp_err
  );
endinterface

// File: rtl/imem_fetch_unit.sv
// Instruction RAM with pipelined fetch, show-ahead response FIFO, flush and program-load port (IMEM_PARITY_EN adds parity).
// Latency: READ_LATENCY cycles from accept to fetch_rsp_valid when nothing is queued ahead.
// Backpressure: requests are credit-limited to READ_LATENCY+1 outstanding words, so responses are never dropped.

module imem_fetch_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         clr,
  input  logic                         push,
  input  logic [WIDTH-1:0]             push_dat,
  input  logic                         pop,
  output logic [WIDTH-1:0]             head_dat,
  output logic [$clog2(DEPTH+1)-1:0]   count
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_dat;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  assign head_dat = mem[rd_ptr];
endmodule

module imem_fetch_unit #(
  parameter int                    ADDR_WIDTH   = 12,
  parameter int                    DATA_WIDTH   = 32,
  parameter int                    READ_LATENCY = 1,
  parameter logic [DATA_WIDTH-1:0] NOP_WORD     = DATA_WIDTH'(32'h0000_0013)
) (
  input logic         clk,
  input logic         rst_n,
  imem_fetch_if.slave bus
);
  localparam int PAW   = ADDR_WIDTH + 2;
  localparam int DEPTH = READ_LATENCY + 1;
  localparam int RSPW  = PAW + 1 + DATA_WIDTH;
  localparam int CW    = $clog2(DEPTH + 1);
  localparam int WORDS = 2 ** ADDR_WIDTH;

  typedef struct packed {
    logic [PAW-1:0]        addr;
    logic                  err;
    logic [DATA_WIDTH-1:0] dat;
  } rsp_t;

  logic [DATA_WIDTH-1:0] mem [WORDS];
  logic                  wr_en;
  logic                  accept;
  logic                  rdy_en;

  logic [READ_LATENCY-1:0] st_vld;
  logic [PAW-1:0]          st_addr [READ_LATENCY];
  logic [ADDR_WIDTH-1:0]   rd_idx;
  logic [DATA_WIDTH-1:0]   rd_dat;
  logic                    par_err;

  rsp_t          tail;
  rsp_t          fifo_head;
  rsp_t          head;
  logic [CW-1:0] fifo_cnt;
  logic          fifo_empty;
  logic          fifo_push;
  logic          fifo_pop;
  logic          rsp_vld;
  logic          pop;
  logic [7:0]    outstanding;

  assign wr_en  = bus.load_mode && bus.load_we;
  assign accept = bus.fetch_req_valid && bus.fetch_req_ready;

  always_ff @(posedge clk) begin
    if (wr_en) mem[bus.load_addr] <= bus.load_data;
  end

  // The RAM is read on the edge that loads the last stage; a same-edge write is seen next time (read-first).
  if (READ_LATENCY == 1) begin : g_rd_direct
    assign rd_idx = bus.fetch_addr[PAW-1:2];
  end else begin : g_rd_staged
    assign rd_idx = st_addr[READ_LATENCY-2][PAW-1:2];
  end

  always_ff @(posedge clk) begin
    rd_dat <= mem[rd_idx];
  end

`ifdef IMEM_PARITY_EN
  logic par_mem [WORDS];
  logic rd_par;

  always_ff @(posedge clk) begin
    if (wr_en) par_mem[bus.load_addr] <= ^bus.load_data;
  end

  always_ff @(posedge clk) begin
    rd_par <= par_mem[rd_idx];
  end

  assign par_err = rd_par ^ (^rd_dat);
`else
  assign par_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_vld <= '0;
      rdy_en <= 1'b0;
    end else begin
      rdy_en <= 1'b1;
      if (bus.fetch_flush) begin
        st_vld <= '0;
      end else begin
        st_vld[0] <= accept;
        for (int k = 1; k < READ_LATENCY; k++) st_vld[k] <= st_vld[k-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    st_addr[0] <= bus.fetch_addr;
    for (int k = 1; k < READ_LATENCY; k++) st_addr[k] <= st_addr[k-1];
  end

  always_comb begin
    tail.addr = st_addr[READ_LATENCY-1];
    tail.err  = (|st_addr[READ_LATENCY-1][1:0]) | par_err;
    tail.dat  = tail.err ? NOP_WORD : rd_dat;
  end

  // The last stage bypasses the FIFO when it is empty, which is what keeps the latency at READ_LATENCY.
  assign fifo_empty = (fifo_cnt == '0);
  assign rsp_vld    = !fifo_empty || st_vld[READ_LATENCY-1];
  assign head       = fifo_empty ? tail : fifo_head;
  assign pop        = rsp_vld && bus.fetch_rsp_ready;
  assign fifo_pop   = pop && !fifo_empty;
  assign fifo_push  = st_vld[READ_LATENCY-1] && !(pop && fifo_empty);

  imem_fetch_fifo #(
    .WIDTH (RSPW),
    .DEPTH (DEPTH)
  ) u_rsp_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (bus.fetch_flush),
    .push     (fifo_push),
    .push_dat (tail),
    .pop      (fifo_pop),
    .head_dat (fifo_head),
    .count    (fifo_cnt)
  );

  always_comb begin
    outstanding = 8'(fifo_cnt);
    for (int k = 0; k < READ_LATENCY; k++) outstanding = outstanding + 8'(st_vld[k]);
    outstanding = outstanding - 8'(pop);
  end

  assign bus.fetch_req_ready = rdy_en && !bus.load_mode && !bus.fetch_flush &&
                               (outstanding < 8'(READ_LATENCY + 1));

  always_comb begin
    bus.fetch_rsp_valid = rsp_vld;
    bus.fetch_rsp_data  = rsp_vld ? head.dat  : '0;
    bus.fetch_rsp_addr  = rsp_vld ? head.addr : '0;
    bus.fetch_rsp_err   = rsp_vld ? head.err  : 1'b0;
  end
endmodule
